// File: rtl/aq_ejpeg_bitpack.sv
// JPEG entropy bit packer: packs variable-width codes MSB-first into 32-bit words,
// inserting a 0x00 after every 0xFF byte and padding with 1-bits at end of scan.
//
// state | meaning
// RUN   | accepting codes, emitting full words
// FLUSH | no input; pad partial byte with 1s and drain accumulator
// FINAL | present the last (possibly empty) word with OutLast=1
module aq_ejpeg_bitpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        InEnable,
  output logic        InReady,
  input  logic [15:0] InCode,
  input  logic [4:0]  InWidth,
  input  logic        InFlush,
  output logic        OutEnable,
  input  logic        OutReady,
  output logic [31:0] OutData,
  output logic [3:0]  OutByteEn,
  output logic        OutLast,
  output logic        Idle
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FINAL = 2'd2} stateT;

  stateT       state, stateNext;
  logic [31:0] acc, accNext;
  logic [31:0] word, wordNext;
  logic [5:0]  bitCount, bitCountNext;
  logic [2:0]  byteCount, byteCountNext;
  logic        stuffPending, stuffNext;

  logic        accept, handshake, room, extract, insertStuff, writeByte, padNow;
  logic [4:0]  widthEff;
  logic [5:0]  remain;
  logic [31:0] codeAligned, shifted;
  logic [7:0]  byteVal;
  logic [1:0]  slot;
  logic [2:0]  byteBase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (InFlush) stateNext = FLUSH;
      FLUSH:   if (bitCount == 6'd0 && !stuffPending && byteCount != 3'd4) stateNext = FINAL;
      FINAL:   if (handshake) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    InReady   = (state == RUN) && (bitCount <= 6'd16);
    OutEnable = (byteCount == 3'd4) || (state == FINAL);
    OutLast   = (state == FINAL);
    OutData   = word;
    Idle      = (state == RUN) && (bitCount == 6'd0) && (byteCount == 3'd0) && !stuffPending;
    OutByteEn = 4'b0000;
    if (state == FINAL) begin
      case (byteCount)
        3'd1:    OutByteEn = 4'b1000;
        3'd2:    OutByteEn = 4'b1100;
        3'd3:    OutByteEn = 4'b1110;
        default: OutByteEn = 4'b0000;
      endcase
    end else if (byteCount == 3'd4) begin
      OutByteEn = 4'b1111;
    end
  end

  // A full word being handed off this cycle frees slot 0 for a byte moved now.
  assign accept      = InEnable && InReady;
  assign handshake   = OutEnable && OutReady;
  assign room        = (state != FINAL) && ((byteCount < 3'd4) || handshake);
  assign insertStuff = room && stuffPending;
  assign extract     = room && !stuffPending && (bitCount >= 6'd8);
  assign writeByte   = insertStuff || extract;
  assign byteVal     = insertStuff ? 8'h00 : acc[31:24];
  assign padNow      = (state == FLUSH) && (bitCount != 6'd0) && (bitCount < 6'd8);
  assign widthEff    = (InWidth > 5'd16) ? 5'd16 : InWidth;
  assign remain      = extract ? (bitCount - 6'd8) : bitCount;
  assign codeAligned = {InCode, 16'h0000} << (5'd16 - widthEff);
  assign shifted     = extract ? {acc[23:0], 8'h00} : acc;
  assign byteBase    = handshake ? 3'd0 : byteCount;
  assign slot        = byteBase[1:0];

  always_comb begin
    accNext      = shifted;
    bitCountNext = remain;
    if (accept) begin
      accNext      = shifted | (codeAligned >> remain);
      bitCountNext = remain + {1'b0, widthEff};
    end
    if (padNow) begin
      accNext[31:24] = acc[31:24] | (8'hFF >> bitCount[2:0]);
      bitCountNext   = 6'd8;
    end

    stuffNext = stuffPending;
    if (insertStuff) stuffNext = 1'b0;
    if (extract && acc[31:24] == 8'hFF) stuffNext = 1'b1;

    wordNext      = handshake ? 32'h0 : word;
    byteCountNext = byteBase + {2'b00, writeByte};
    if (writeByte) begin
      case (slot)
        2'd0:    wordNext[31:24] = byteVal;
        2'd1:    wordNext[23:16] = byteVal;
        2'd2:    wordNext[15:8]  = byteVal;
        default: wordNext[7:0]   = byteVal;
      endcase
    end

    if (state == FINAL && handshake) begin
      accNext       = 32'h0;
      bitCountNext  = 6'd0;
      stuffNext     = 1'b0;
      wordNext      = 32'h0;
      byteCountNext = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc          <= 32'h0;
      bitCount     <= 6'd0;
      word         <= 32'h0;
      byteCount    <= 3'd0;
      stuffPending <= 1'b0;
    end else begin
      acc          <= accNext;
      bitCount     <= bitCountNext;
      word         <= wordNext;
      byteCount    <= byteCountNext;
      stuffPending <= stuffNext;
    end
  end

endmodule

// File: tb/tb_aq_ejpeg_bitpack.sv
// Bench for aq_ejpeg_bitpack: directed scans plus random scans, compared against a
// bit-queue model that byte-splits, stuffs and pads the accepted code stream.
module tb_aq_ejpeg_bitpack;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        InEnable = 1'b0;
  logic        InReady;
  logic [15:0] InCode = 16'h0;
  logic [4:0]  InWidth = 5'd0;
  logic        InFlush = 1'b0;
  logic        OutEnable;
  logic        OutReady = 1'b1;
  logic [31:0] OutData;
  logic [3:0]  OutByteEn;
  logic        OutLast;
  logic        Idle;

  aq_ejpeg_bitpack dut (
    .clk(clk), .rst(rst), .InEnable(InEnable), .InReady(InReady), .InCode(InCode),
    .InWidth(InWidth), .InFlush(InFlush), .OutEnable(OutEnable), .OutReady(OutReady),
    .OutData(OutData), .OutByteEn(OutByteEn), .OutLast(OutLast), .Idle(Idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int readyMode = 0;
  bit          bitQ[$];
  logic [36:0] expQ[$];
  logic [36:0] gotQ[$];

  initial forever begin
    @(posedge clk); #1;
    case (readyMode)
      0:       OutReady = 1'b1;
      1:       OutReady = ($urandom_range(0, 2) != 0);
      default: OutReady = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (rst && OutEnable && OutReady) gotQ.push_back({OutLast, OutByteEn, OutData});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sendCode(input logic [15:0] code, input logic [4:0] width);
    int n = 0;
    int w;
    InEnable = 1'b1; InCode = code; InWidth = width;
    @(negedge clk);
    while (!InReady && n < 300) begin n++; @(negedge clk); end
    check("accept_wait", 64'(n < 300), 64'd1);
    if (InReady) begin
      w = (width > 5'd16) ? 16 : int'(width);
      for (int i = w - 1; i >= 0; i--) bitQ.push_back(code[i]);
    end
    @(posedge clk); #1;
    InEnable = 1'b0;
  endtask

  task automatic modelFlush();
    logic [7:0]  b;
    logic [7:0]  byteQ[$];
    logic [31:0] d;
    logic [7:0]  m;
    int n;
    while (bitQ.size() % 8 != 0) bitQ.push_back(1'b1);
    while (bitQ.size() > 0) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitQ.pop_front()};
      byteQ.push_back(b);
      if (b == 8'hFF) byteQ.push_back(8'h00);
    end
    while (byteQ.size() >= 4) begin
      d = {byteQ[0], byteQ[1], byteQ[2], byteQ[3]};
      repeat (4) void'(byteQ.pop_front());
      expQ.push_back({1'b0, 4'b1111, d});
    end
    n = byteQ.size();
    d = 32'h0;
    for (int i = 0; i < n; i++) d[31 - 8*i -: 8] = byteQ[i];
    m = 8'h0F << (4 - n);
    expQ.push_back({1'b1, m[3:0], d});
  endtask

  task automatic doFlush();
    InFlush = 1'b1;
    @(posedge clk); #1;
    InFlush = 1'b0;
    modelFlush();
  endtask

  task automatic checkStream(input string tag);
    int n = 0;
    while (gotQ.size() < expQ.size() && n < 3000) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
    while (gotQ.size() > 0 && expQ.size() > 0)
      check({tag, "_word"}, 64'(gotQ.pop_front()), 64'(expQ.pop_front()));
    check({tag, "_idle"}, 64'(Idle), 64'd1);
    gotQ.delete(); expQ.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] bp[8];
    int idx;
    int n;
    logic took;
    bp = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h1357, 16'h2468, 16'h0A0B, 16'h0C0D};

    // power-up reset
    repeat (2) @(negedge clk);
    check("rst_inready",  64'(InReady),   64'd1);
    check("rst_idle",     64'(Idle),      64'd1);
    check("rst_outen",    64'(OutEnable), 64'd0);
    check("rst_data",     64'(OutData),   64'd0);
    check("rst_byteen",   64'(OutByteEn), 64'd0);
    check("rst_last",     64'(OutLast),   64'd0);
    @(posedge clk); #1; rst = 1'b1;

    // packing
    sendCode(16'h0012, 5'd8); sendCode(16'h0034, 5'd8);
    sendCode(16'h0056, 5'd8); sendCode(16'h0078, 5'd8);
    n = 0;
    while (gotQ.size() < 1 && n < 50) begin @(negedge clk); n++; end
    check("pack_first", 64'((gotQ.size() > 0) ? gotQ[0] : 37'bx), {27'd0, 1'b0, 4'b1111, 32'h12345678});
    @(posedge clk); #1;
    doFlush(); checkStream("pack");

    // stuffing
    sendCode(16'hFFAB, 5'd16); sendCode(16'hCDEF, 5'd16);
    doFlush(); checkStream("stuff");

    // padding, with junk above the width
    sendCode(16'hFFFD, 5'd3);
    doFlush(); checkStream("pad");

    // padded 0xFF
    sendCode(16'h807F, 5'd7);
    doFlush(); checkStream("padff");

    // zero-width and oversize widths
    sendCode(16'hABCD, 5'd0); sendCode(16'h1234, 5'd31); sendCode(16'hF0F0, 5'd17);
    doFlush(); checkStream("widths");

    // empty flush
    doFlush(); checkStream("empty");

    // backpressure
    readyMode = 2;
    @(posedge clk); #1;
    InEnable = 1'b1; InWidth = 5'd16; idx = 0; InCode = bp[0];
    repeat (24) begin
      @(negedge clk);
      took = InReady;
      if (took) for (int i = 15; i >= 0; i--) bitQ.push_back(InCode[i]);
      @(posedge clk); #1;
      if (took) begin idx++; InCode = bp[idx % 8]; end
    end
    InEnable = 1'b0;
    @(negedge clk);
    check("bp_inready", 64'(InReady),   64'd0);
    check("bp_outen",   64'(OutEnable), 64'd1);
    check("bp_taken",   64'(idx),       64'd4);
    check("bp_nowords", 64'(gotQ.size()), 64'd0);
    @(posedge clk); #1;
    readyMode = 0;
    doFlush(); checkStream("bp");

    // random scans
    readyMode = 1;
    for (int s = 0; s < 10; s++) begin
      n = $urandom_range(1, 14);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) sendCode(16'hFFFF, 5'd16);
        else sendCode(16'($urandom), 5'($urandom_range(0, 31)));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      doFlush(); checkStream("rand");
    end
    readyMode = 0;
    @(posedge clk); #1;

    // reset mid-word with a word on offer
    readyMode = 2;
    @(posedge clk); #1;
    sendCode(16'h00AA, 5'd8); sendCode(16'h00BB, 5'd8);
    sendCode(16'h00CC, 5'd8); sendCode(16'h00DD, 5'd8);
    sendCode(16'h00EE, 5'd8);
    n = 0;
    @(negedge clk);
    while (!OutEnable && n < 50) begin @(negedge clk); n++; end
    check("mid_outen_before", 64'(OutEnable), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_outen_after", 64'(OutEnable), 64'd0);
    check("mid_data",        64'(OutData),   64'd0);
    check("mid_byteen",      64'(OutByteEn), 64'd0);
    check("mid_inready",     64'(InReady),   64'd1);
    check("mid_idle",        64'(Idle),      64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    readyMode = 0;
    bitQ.delete(); gotQ.delete(); expQ.delete();
    @(negedge clk);
    check("post_inready", 64'(InReady), 64'd1);
    check("post_idle",    64'(Idle),    64'd1);
    @(posedge clk); #1;
    sendCode(16'h005A, 5'd8);
    doFlush(); checkStream("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aq_ejpeg_bitpack.md
AQ_EJPEG_BITPACK -- requirements
Module: aq_ejpeg_bitpack

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have ports as follows:
  - clk  in  1  sole clock; all state changes on the rising edge.
  - rst  in  1  reset, asynchronous, active-low.
  - InEnable  in  1  code word valid.
  - InReady  out  1  code word can be accepted.
  - InCode  in  16  code bits, right-aligned; only the low InWidth bits are used.
  - InWidth  in  5  bit count, 0..16.
  - InFlush  in  1  end-of-scan request, single-cycle pulse.
  - OutEnable  out  1  output word valid.
  - OutReady  in  1  sink accepts the word.
  - OutData  out  32  byte-stuffed stream word, first byte in [31:24].
  - OutByteEn  out  4  valid bytes, MSB-first ([3]=bits 31:24).
  - OutLast  out  1  final word of the scan.
  - Idle  out  1  no data held and no flush in progress.

Function
REQ-003 SHALL accept a code when InEnable && InReady, and SHALL append its low InWidth bits MSB-first to a 32-bit left-aligned bit accumulator with count BitCount (0..32).
REQ-004 SHALL treat InWidth 17..31 as 16 and InWidth 0 as an accepted no-op; InCode bits above InWidth SHALL be masked.
REQ-005 SHALL drive InReady=1 only in state RUN with BitCount<=16.
REQ-006 SHALL move at most one byte per cycle into a 4-byte word assembler (ByteCount 0..4), using the top 8 accumulator bits, when BitCount>=8, ByteCount<4, and StuffPending=0.
REQ-007 SHALL set StuffPending when the moved byte is 0xFF; in the next eligible cycle (ByteCount<4) it SHALL insert 0x00 instead of an accumulator byte and clear StuffPending.
REQ-008 SHALL permit accept and extract in one cycle: BitCount_next = BitCount - 8*extract + width*accept, with the new bits placed after the shifted remainder.
REQ-009 SHALL assert OutEnable when ByteCount==4, or in state FINAL; OutData, OutByteEn and OutLast SHALL hold stable until OutEnable && OutReady.
REQ-010 SHALL clear the word on handshake; a byte extracted in the same cycle SHALL land in slot 0 (ByteCount_next=1).
REQ-011 SHALL drive OutByteEn=4'b1111 and OutLast=0 for full words in RUN/FLUSH.
REQ-012 SHALL latency: a byte becomes extractable the cycle after its bits are accepted; OutEnable rises the cycle after the 4th byte is written.
REQ-013 SHALL implement a state machine with states RUN, FLUSH and FINAL:
  - RUN -> FLUSH on InFlush (a code accepted in the same cycle is included).
  - InFlush outside RUN is ignored.
REQ-014 SHALL behave as follows in FLUSH:
  - InReady=0.
  - If 0<BitCount<8, pad with 1-bits to 8 in one cycle.
  - Drain per REQ-006/007, including stuffing of a pad-produced 0xFF.
  - -> FINAL once BitCount==0 && StuffPending==0 && no full word pending.
REQ-015 SHALL behave as follows in FINAL:
  - Present the remaining ByteCount bytes left-aligned, unused bytes 0x00.
  - OutByteEn has ByteCount leading ones (4'b0000 if empty).
  - OutLast=1.
  - On handshake: clear all state -> RUN.
REQ-016 SHALL drive Idle=1 when state==RUN && BitCount==0 && ByteCount==0 && StuffPending==0.

Reset
REQ-017 SHALL, while rst=0:
  - state=RUN, BitCount=0, ByteCount=0, StuffPending=0.
  - OutEnable=0, OutData=0, OutByteEn=0, OutLast=0.
  - InReady=1, Idle=1.
REQ-018 SHALL, on assertion of rst mid-operation, discard all held bits and bytes immediately; the first cycle after release SHALL behave as after power-up.

Verification
REQ-019 SHALL cover reset: assert rst mid-word with OutEnable=1 -> OutEnable=0 immediately; InReady=1 and Idle=1 after release.
REQ-020 SHALL cover packing: four 8-bit codes 0x12,0x34,0x56,0x78 -> one word 0x12345678, ByteEn 4'b1111, OutLast=0.
REQ-021 SHALL cover stuffing: 16-bit 0xFFAB then 16-bit 0xCDEF, then InFlush -> words:
  - 0xFF00ABCD, ByteEn 1111, OutLast=0.
  - 0xEF000000, ByteEn 1000, OutLast=1.
REQ-022 SHALL cover padding: 3-bit 3'b101, then InFlush -> 0xBF000000, ByteEn 1000, OutLast=1.
REQ-023 SHALL cover padded 0xFF: 7-bit 7'h7F, then InFlush -> 0xFF000000, ByteEn 1100, OutLast=1.
REQ-024 SHALL cover backpressure and empty flush:
  - OutReady=0 with a full word and continuous 16-bit input: InReady drops once BitCount>16.
  - Release OutReady: all bits emitted in order, none lost or duplicated.
  - InFlush when Idle: one word, ByteEn 0000, OutLast=1.
